smoldvi_tmds_encoder: RTL and testbench



---
 rtl/smoldvi_tmds_encoder.sv | 178 +++++++++++++++++
 tb/tb_smoldvi_tmds_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/smoldvi_tmds_encoder.sv
// Per-lane TMDS encoder (DVI 8b/10b video, control, optional TERC4/guard via SMOLDVI_TMDS_TERC4_EN).
// Latency: input register, q_m stage, symbol stage (q valid after edge N+2); one symbol per beat, no stall.
module smoldvi_tmds_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [1:0] mode,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic [3:0] aux,
    output logic [9:0] q
);

    localparam logic [1:0] MODE_VIDEO = 2'd1;
    localparam logic [9:0] CTL_00     = 10'b1101010100;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] cb);
        logic [9:0] s;
        case (cb)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

`ifdef SMOLDVI_TMDS_TERC4_EN
    localparam logic [1:0] MODE_TERC4 = 2'd2;
    localparam logic [1:0] MODE_GUARD = 2'd3;
    localparam logic [9:0] GUARD_SYM  = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

    function automatic logic [9:0] terc4_sym(input logic [3:0] nib);
        logic [9:0] s;
        case (nib)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    logic [3:0] in_aux_d, in_aux_q;
    logic [3:0] s1_aux_d, s1_aux_q;

    always_comb begin
        in_aux_d = aux;
        s1_aux_d = in_aux_q;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            in_aux_q <= '0;
            s1_aux_q <= '0;
        end else begin
            in_aux_q <= in_aux_d;
            s1_aux_q <= s1_aux_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (^aux) ^ (CHANNEL == 1);
`endif

    // Input register stage.
    logic [1:0] in_mode_d, in_mode_q;
    logic [7:0] in_d_d,    in_d_q;
    logic [1:0] in_c_d,    in_c_q;

    always_comb begin
        in_mode_d = mode;
        in_d_d    = d;
        in_c_d    = c;
    end

    // Stage 1: transition-minimised q_m.
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] s1_qm_d,   s1_qm_q;
    logic [1:0] s1_mode_d, s1_mode_q;
    logic [1:0] s1_c_d,    s1_c_q;

    always_comb begin
        n1d        = popcount8(in_d_q);
        use_xnor   = (n1d > 4'd4) || (n1d == 4'd4 && !in_d_q[0]);
        s1_qm_d    = '0;
        s1_qm_d[0] = in_d_q[0];
        for (int i = 1; i < 8; i++) begin
            s1_qm_d[i] = use_xnor ? ~(s1_qm_d[i-1] ^ in_d_q[i]) : (s1_qm_d[i-1] ^ in_d_q[i]);
        end
        s1_qm_d[8] = ~use_xnor;
        s1_mode_d  = in_mode_q;
        s1_c_d     = in_c_q;
    end

    // Stage 2: DC balancing against the running disparity.
    logic [7:0]        qm;
    logic              qm8;
    logic [3:0]        n1;
    logic signed [4:0] diff;
    logic [9:0]        q_d, q_q;
    logic signed [4:0] cnt_d, cnt_q;

    always_comb begin
        qm    = s1_qm_q[7:0];
        qm8   = s1_qm_q[8];
        n1    = popcount8(qm);
        // N1 - N0 == 2*N1 - 8, fits in five bits for 0..8 ones.
        diff  = $signed({n1, 1'b0} - 5'd8);
        q_d   = ctl_sym(s1_c_q);
        cnt_d = '0;
        case (s1_mode_q)
            MODE_VIDEO: begin
                if (cnt_q == 5'sd0 || n1 == 4'd4) begin
                    q_d   = {~qm8, qm8, qm8 ? qm : ~qm};
                    cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((cnt_q > 5'sd0 && n1 > 4'd4) || (cnt_q < 5'sd0 && n1 < 4'd4)) begin
                    q_d   = {1'b1, qm8, ~qm};
                    cnt_d = cnt_q + (qm8 ? 5'sd2 : 5'sd0) - diff;
                end else begin
                    q_d   = {1'b0, qm8, qm};
                    cnt_d = cnt_q - (qm8 ? 5'sd0 : 5'sd2) + diff;
                end
            end
`ifdef SMOLDVI_TMDS_TERC4_EN
            MODE_TERC4: q_d = terc4_sym(s1_aux_q);
            MODE_GUARD: q_d = GUARD_SYM;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            in_mode_q <= '0;
            in_d_q    <= '0;
            in_c_q    <= '0;
            s1_mode_q <= '0;
            s1_c_q    <= '0;
            s1_qm_q   <= '0;
            q_q       <= CTL_00;
            cnt_q     <= '0;
        end else begin
            in_mode_q <= in_mode_d;
            in_d_q    <= in_d_d;
            in_c_q    <= in_c_d;
            s1_mode_q <= s1_mode_d;
            s1_c_q    <= s1_c_d;
            s1_qm_q   <= s1_qm_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_smoldvi_tmds_encoder.sv
// Scoreboard bench for smoldvi_tmds_encoder: stimulus pushes expected symbols, a monitor pops one per cycle.
module tb_smoldvi_tmds_encoder;

    localparam int TB_CHANNEL = 1;
    localparam logic [9:0] CTL_TBL [4] = '{10'b1101010100, 10'b0010101011,
                                           10'b0101010100, 10'b1010101011};
`ifdef SMOLDVI_TMDS_TERC4_EN
    localparam logic [9:0] TERC4_TBL [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_CH1  = 10'b0100110011;
    localparam logic [9:0] GB_CH02 = 10'b1011001100;
`endif

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic [1:0] mode    = 2'd0;
    logic [7:0] d       = 8'd0;
    logic [1:0] c       = 2'd0;
    logic [3:0] aux     = 4'd0;
    logic [9:0] q;

    smoldvi_tmds_encoder #(.CHANNEL(TB_CHANNEL)) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .mode    (mode),
        .d       (d),
        .c       (c),
        .aux     (aux),
        .q       (q)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [9:0] sym;
        bit         video;
        logic [7:0] dat;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   m_cnt    = 0;
    int   obs_disp = 0;

    // Reference encoder: the DVI rules in integer arithmetic.
    function automatic logic [9:0] ref_video(input logic [7:0] dd, input int cnt_in, output int cnt_out);
        int         ones, n1, n0;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] s;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(dd[i]);
        xn    = (ones > 4) || (ones == 4 && dd[0] == 1'b0);
        qm[0] = dd[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0) begin
            s       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            s       = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            s       = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in - 2 * int'(!qm[8]) + n1 - n0;
        end
        return s;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] m;
        logic [7:0] o;
        m    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = m[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        return o;
    endfunction

    function automatic int sym_disp(input logic [9:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(s[i]);
        return 2 * ones - 10;
    endfunction

    // Drive one beat (sampled at the next edge) and queue the symbol it should produce.
    task automatic issue(input logic r, input logic [1:0] m, input logic [7:0] dd,
                         input logic [1:0] cc, input logic [3:0] aa);
        exp_t e;
        int   nc;
        rst_pix = r;
        mode    = m;
        d       = dd;
        c       = cc;
        aux     = aa;
        e.sym   = CTL_TBL[0];
        e.video = 1'b0;
        e.dat   = dd;
        e.cnt   = 0;
        if (r) begin
            // Reset flushes the two symbols already in flight.
            m_cnt = 0;
            for (int i = sb.size() - 2; i < sb.size(); i++) begin
                if (i >= 0) sb[i] = e;
            end
        end else if (m == 2'd1) begin
            e.sym   = ref_video(dd, m_cnt, nc);
            m_cnt   = nc;
            e.video = 1'b1;
            e.cnt   = nc;
        end else begin
            m_cnt = 0;
            e.sym = CTL_TBL[cc];
`ifdef SMOLDVI_TMDS_TERC4_EN
            if (m == 2'd2) e.sym = TERC4_TBL[aa];
            else if (m == 2'd3) e.sym = (TB_CHANNEL == 1) ? GB_CH1 : GB_CH02;
`endif
        end
        sb.push_back(e);
        @(posedge clk_pix);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] dec;
        forever begin
            @(negedge clk_pix);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== e.sym) begin
                    errors++;
                    $display("FAIL symbol: q=%b expected %b at %0t", q, e.sym, $time);
                end
                if (e.video) begin
                    dec = tmds_decode(q);
                    checks++;
                    if (dec !== e.dat) begin
                        errors++;
                        $display("FAIL decode: got %h expected %h at %0t", dec, e.dat, $time);
                    end
                    obs_disp += sym_disp(q);
                    checks++;
                    if (obs_disp != e.cnt) begin
                        errors++;
                        $display("FAIL disparity: observed %0d expected %0d at %0t", obs_disp, e.cnt, $time);
                    end
                    checks++;
                    if (obs_disp < -16 || obs_disp > 15) begin
                        errors++;
                        $display("FAIL disparity_range: observed %0d outside -16..15 at %0t", obs_disp, $time);
                    end
                end else begin
                    obs_disp = 0;
                end
            end
        end
    end

    initial begin : stimulus
        exp_t p;
        p.sym   = CTL_TBL[0];
        p.video = 1'b0;
        p.dat   = 8'd0;
        p.cnt   = 0;
        sb.push_back(p);
        sb.push_back(p);

        repeat (3) issue(1'b1, 2'd0, 8'h00, 2'd0, 4'd0);
        repeat (4) issue(1'b0, 2'd0, 8'h00, 2'd0, 4'd0);
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd0, 8'h00, 2'(i), 4'd0);
        repeat (18) issue(1'b0, 2'd1, 8'h00, 2'd0, 4'd0);

        issue(1'b0, 2'd2, 8'h00, 2'd0, 4'd0);
        issue(1'b0, 2'd3, 8'h00, 2'd0, 4'd0);
        for (int i = 0; i < 16; i++) issue(1'b0, 2'd2, 8'($urandom), 2'($urandom), 4'(i));

        repeat (20) issue(1'b0, 2'd1, 8'($urandom), 2'd0, 4'd0);
        issue(1'b1, 2'd1, 8'($urandom), 2'd0, 4'd0);
        repeat (20) issue(1'b0, 2'd1, 8'($urandom), 2'd0, 4'd0);

        repeat (10000) issue(1'b0, 2'd1, 8'($urandom), 2'($urandom), 4'($urandom));

        repeat (3000) issue($urandom_range(0, 199) == 0, 2'($urandom), 8'($urandom),
                            2'($urandom), 4'($urandom));
        repeat (4) issue(1'b0, 2'd0, 8'h00, 2'd0, 4'd0);

        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            @(negedge clk_pix);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d symbols still pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
